// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the HD44780 write sequencer.
//               - FSM state encoding (3-bit, IDLE = 0)
//               - Clear/home command constants
//               - FIFO entry width ({rs, data})
//               - Helper that classifies clear/home commands
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4
    } lcd_state_t;

    localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME_MASK = 8'hFC;
    localparam int         LCD_ENTRY_W       = 9;

    // Clear (0x01) and the return-home encodings (0x02, 0x03) need the long
    // execution wait. They are command writes whose upper six bits are zero
    // and whose value is at least the clear code.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data & LCD_CMD_HOME_MASK) == 8'h00) && (data >= LCD_CMD_CLEAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with asynchronous active-low reset.
//               Pointers carry one extra wrap bit so full and empty are
//               distinguished without a separate counter. A push on a full
//               FIFO is accepted only when a pop happens on the same edge.
// Ports       : clk_out, rst_n       - clock / async active-low reset
//               push, din            - write request and entry
//               pop, dout            - read request and head entry (show-ahead)
//               full, empty, level   - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk_out,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic             w_do_pop;
    logic             w_do_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign level = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];

    assign w_do_pop  = pop && !empty;
    // When full, the write slot is the slot being popped, so a simultaneous
    // pop frees exactly the room the push needs.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; flushing is done by resetting the pointers.
    always_ff @(posedge clk_out) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_write_sequencer
// Description : Buffers CPU byte writes and replays them onto an HD44780
//               8-bit bus with setup / enable pulse / hold / execution timing.
//               Clear and home commands get the long execution wait.
// Ports       : clk_out, rst_n           - clock / async active-low reset
//               wr_en, wr_rs, wr_data    - MMIO write strobe, rs, byte
//               lcd_data, lcd_rs, lcd_rw,
//               lcd_enable               - LCD pins (rw tied low)
//               busy                     - FIFO non-empty or FSM active
//               fifo_level               - FIFO occupancy
//               overflow                 - sticky dropped-write flag
//               drop_count               - saturating drop counter
//                                          (only with LCD_DROP_COUNT_EN)
// Options     : `define LCD_DROP_COUNT_EN adds the drop_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_sequencer
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH       = 8,
    parameter int SETUP_CYCLES     = 1,
    parameter int PULSE_CYCLES     = 2,
    parameter int HOLD_CYCLES      = 1,
    parameter int EXEC_CYCLES      = 4,
    parameter int LONG_EXEC_CYCLES = 40
) (
    input  logic                          clk_out,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic                          wr_rs,
    input  logic [7:0]                    wr_data,
    output logic [7:0]                    lcd_data,
    output logic                          lcd_rs,
    output logic                          lcd_rw,
    output logic                          lcd_enable,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef LCD_DROP_COUNT_EN
    output logic [7:0]                    drop_count,
`endif
    output logic                          overflow
);

    // One down-counter serves every timed state, so it is sized for the
    // longest of the configured durations.
    localparam int c_max_a   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int c_max_b   = (HOLD_CYCLES > LONG_EXEC_CYCLES) ? HOLD_CYCLES : LONG_EXEC_CYCLES;
    localparam int c_max_cnt = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_cnt_w   = (c_max_cnt > 1) ? $clog2(c_max_cnt) : 1;

    localparam logic [c_cnt_w-1:0] c_ld_setup = c_cnt_w'(SETUP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_ld_pulse = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_ld_hold  = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_ld_exec  = c_cnt_w'(EXEC_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_ld_long  = c_cnt_w'(LONG_EXEC_CYCLES - 1);

    lcd_state_t                  r_state;
    lcd_state_t                  w_state_next;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [c_cnt_w-1:0]          w_cnt_next;
    logic                        w_pop;
    logic                        r_enable;
    logic [7:0]                  r_data;
    logic                        r_rs;
    logic                        r_overflow;
    logic                        w_drop;

    logic [LCD_ENTRY_W-1:0]      w_fifo_din;
    logic [LCD_ENTRY_W-1:0]      w_fifo_dout;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_level;

    assign w_fifo_din = {wr_rs, wr_data};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LCD_ENTRY_W)
    ) u_fifo (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .push    (wr_en),
        .pop     (w_pop),
        .din     (w_fifo_din),
        .dout    (w_fifo_dout),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty),
        .level   (w_fifo_level)
    );

    // A write is lost only when the FIFO is full and the sequencer is not
    // freeing a slot on the same edge.
    assign w_drop = wr_en && w_fifo_full && !w_pop;

    // ------------------------------------------------------------------
    // FSM: state and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            // Registered from the next state so the E pin is glitch-free.
            r_enable <= (w_state_next == ST_PULSE);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state, counter reload and pop decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_SETUP;
                    w_cnt_next   = c_ld_setup;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_PULSE;
                    w_cnt_next   = c_ld_pulse;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_PULSE: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = c_ld_hold;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_EXEC;
                    w_cnt_next   = is_long_cmd(r_rs, r_data) ? c_ld_long : c_ld_exec;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_EXEC: begin
                if (r_cnt == '0) begin
                    // Chain straight into the next byte to avoid an idle bubble.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_SETUP;
                        w_cnt_next   = c_ld_setup;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus latch: rs/data change only when a byte is popped
    // ------------------------------------------------------------------
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 8'h00;
            r_rs   <= 1'b0;
        end else if (w_pop) begin
            r_rs   <= w_fifo_dout[8];
            r_data <= w_fifo_dout[7:0];
        end
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef LCD_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= 8'h00;
        end else if (w_drop && (r_drop_count != 8'hFF)) begin
            r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign lcd_data   = r_data;
    assign lcd_rs     = r_rs;
    assign lcd_rw     = 1'b0;
    assign lcd_enable = r_enable;
    assign busy       = !w_fifo_empty || (r_state != ST_IDLE);
    assign fifo_level = w_fifo_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lcd_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_write_sequencer
// Description : Self-checking bench for lcd_write_sequencer (default params).
//               A vector table drives single writes and checks latency,
//               pulse width and busy duration; hand-written sequences cover
//               chaining, long-command gaps, reset mid-pulse, full+pop and
//               overflow. A scoreboard queue holds the bytes expected on the
//               bus and is popped on every enable rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_write_sequencer;

    logic       clk_out = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic       wr_rs;
    logic [7:0] wr_data;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_enable;
    logic       busy;
    logic [3:0] fifo_level;
    logic       overflow;
`ifdef LCD_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    lcd_write_sequencer dut (
        .clk_out    (clk_out),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_rs      (wr_rs),
        .wr_data    (wr_data),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_enable (lcd_enable),
        .busy       (busy),
        .fifo_level (fifo_level),
`ifdef LCD_DROP_COUNT_EN
        .drop_count (drop_count),
`endif
        .overflow   (overflow)
    );

    always #5 clk_out = ~clk_out;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         pulse_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] cur_byte  = '0;
    logic       prev_en   = 1'b0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         busy_cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    // Drive one write strobe; it is sampled on the edge inside this task.
    task automatic wr(input logic rs, input logic [7:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_rs   = rs;
        wr_data = d;
        if (accept) exp_q.push_back({rs, d});
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy && c < bound) begin
            tick();
            c++;
        end
        chk("idle_within_bound", {31'd0, busy}, 32'd0);
    endtask

    // Count enable falling edges and check the spacing between them.
    task automatic measure_falls(input int n_falls, input int exp_gap);
        int   last  = -1;
        int   cyc   = 0;
        int   falls = 0;
        logic pe    = lcd_enable;
        while (falls < n_falls && cyc < 500) begin
            tick();
            cyc++;
            if (pe && !lcd_enable) begin
                if (last >= 0) chk("fall_gap", cyc - last, exp_gap);
                last = cyc;
                falls++;
            end
            pe = lcd_enable;
        end
        chk("falls_seen", falls, n_falls);
    endtask

    // Scoreboard monitor: compare the bus on each enable rise and require it
    // to stay put while enable is high.
    always @(negedge clk_out) begin
        if (rst_n) begin
            if (lcd_enable && !prev_en) begin
                pulse_cnt++;
                chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    cur_byte = exp_q.pop_front();
                    chk("bus_byte", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_byte});
                end
            end else if (lcd_enable) begin
                chk("bus_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, cur_byte});
            end
        end
        prev_en = lcd_enable;
    end

    initial begin
        int cyc;
        int en_cnt;
        int first_en;
        int pulses_before;

        vecs[0] = '{1'b1, 8'h41, 9};
        vecs[1] = '{1'b0, 8'h38, 9};
        vecs[2] = '{1'b0, 8'h01, 45};
        vecs[3] = '{1'b0, 8'h02, 45};
        vecs[4] = '{1'b0, 8'h03, 45};
        vecs[5] = '{1'b0, 8'h04, 9};
        vecs[6] = '{1'b0, 8'h00, 9};
        vecs[7] = '{1'b1, 8'h01, 9};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_rs   = 1'b0;
        wr_data = 8'h00;

        // Reset state
        #12;
        chk("rst_lcd_data",   {24'd0, lcd_data}, 32'd0);
        chk("rst_lcd_rs",     {31'd0, lcd_rs}, 32'd0);
        chk("rst_lcd_rw",     {31'd0, lcd_rw}, 32'd0);
        chk("rst_lcd_enable", {31'd0, lcd_enable}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd0);
        chk("rst_level",      {28'd0, fifo_level}, 32'd0);
        chk("rst_overflow",   {31'd0, overflow}, 32'd0);
        #11;
        rst_n = 1'b1;
        tick();

        // Table-driven single writes: latency, pulse width, busy duration.
        for (int v = 0; v < 8; v++) begin
            wr(vecs[v].rs, vecs[v].data, 1'b1);
            cyc      = 0;
            en_cnt   = 0;
            first_en = -1;
            while (busy && cyc < 200) begin
                tick();
                cyc++;
                if (cyc == 1) begin
                    chk("vec_data_n1", {24'd0, lcd_data}, {24'd0, vecs[v].data});
                    chk("vec_rs_n1",   {31'd0, lcd_rs}, {31'd0, vecs[v].rs});
                end
                if (lcd_enable) begin
                    en_cnt++;
                    if (first_en < 0) first_en = cyc;
                end
                chk("vec_rw_low", {31'd0, lcd_rw}, 32'd0);
            end
            chk("vec_busy_cycles", cyc, vecs[v].busy_cycles);
            chk("vec_en_width",    en_cnt, 2);
            chk("vec_en_start",    first_en, 2);
            // Bus holds the last byte while idle.
            tick();
            chk("vec_idle_hold", {23'd0, lcd_rs, lcd_data}, {23'd0, vecs[v].rs, vecs[v].data});
        end

        // Three consecutive writes: pulses 8 cycles apart, order preserved.
        wr(1'b1, 8'h48, 1'b1);
        wr(1'b1, 8'h49, 1'b1);
        wr(1'b1, 8'h21, 1'b1);
        measure_falls(3, 8);
        wait_idle(100);

        // Clear followed by data: long gap.
        wr(1'b0, 8'h01, 1'b1);
        wr(1'b1, 8'h5A, 1'b1);
        measure_falls(2, 44);
        wait_idle(200);

        // Function-set followed by data: normal gap.
        wr(1'b0, 8'h38, 1'b1);
        wr(1'b1, 8'h5A, 1'b1);
        measure_falls(2, 8);
        wait_idle(100);

        // Reset in the middle of the enable pulse.
        wr(1'b1, 8'hA5, 1'b1);     // edge N
        wr(1'b1, 8'hA6, 1'b0);     // edge N+1, flushed by the reset below
        tick();                    // after N+2: enable high
        chk("pre_rst_enable", {31'd0, lcd_enable}, 32'd1);
        chk("pre_rst_level",  {28'd0, fifo_level}, 32'd1);
        #6;                        // past the negedge, before the next posedge
        rst_n = 1'b0;
        #1;
        chk("mid_rst_enable",   {31'd0, lcd_enable}, 32'd0);
        chk("mid_rst_level",    {28'd0, fifo_level}, 32'd0);
        chk("mid_rst_busy",     {31'd0, busy}, 32'd0);
        chk("mid_rst_lcd_data", {24'd0, lcd_data}, 32'd0);
        @(posedge clk_out);
        @(posedge clk_out);
        #3;
        rst_n = 1'b1;
        pulses_before = pulse_cnt;
        repeat (20) tick();
        chk("post_rst_no_pulse", pulse_cnt, pulses_before);
        chk("post_rst_busy",     {31'd0, busy}, 32'd0);

        // Fill behind a clear, then write on the EXEC-expiry pop edge.
        wr(1'b0, 8'h01, 1'b1);     // edge M
        tick();                    // M+1: popped
        for (int i = 0; i < 8; i++) wr(1'b1, 8'h60 + 8'(i), 1'b1);  // M+2..M+9
        chk("full_level",    {28'd0, fifo_level}, 32'd8);
        chk("full_overflow", {31'd0, overflow}, 32'd0);
        repeat (35) tick();        // after M+44
        chk("prepop_level",  {28'd0, fifo_level}, 32'd8);
        wr(1'b1, 8'h70, 1'b1);     // M+45: push with pop while full
        chk("fullpop_level",    {28'd0, fifo_level}, 32'd8);
        chk("fullpop_overflow", {31'd0, overflow}, 32'd0);

        // Ten back-to-back writes at M+46..M+55; only M+53 coincides with a pop.
        for (int i = 0; i < 10; i++) wr(1'b1, 8'h80 + 8'(i), (i == 7));
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        chk("ovf_level", {28'd0, fifo_level}, 32'd8);
`ifdef LCD_DROP_COUNT_EN
        chk("ovf_drop_count", {24'd0, drop_count}, 32'd9);
`endif
        wait_idle(2000);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_level",        {28'd0, fifo_level}, 32'd0);
        chk("ovf_sticky",         {31'd0, overflow}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
